// File: rtl/errbit_pattern_gen.sv
// Error-pattern generator: builds an ERR_WIDTH-bit vector with exactly the
// requested number of ones, placing bits at LFSR-chosen positions.
module errbit_pattern_gen #(
  parameter int          ERR_WIDTH   = 128,
  parameter int          COUNT_WIDTH = 8,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   seed_load,
  input  logic [31:0]            seed,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] target_weight,
  output logic                   busy,
  output logic                   sat,
  output logic                   err_vec_valid,
  input  logic                   err_vec_ready,
  output logic [ERR_WIDTH-1:0]   err_vec,
  output logic [COUNT_WIDTH-1:0] err_weight
);

  localparam int                     IW    = (ERR_WIDTH > 1) ? $clog2(ERR_WIDTH) : 1;
  localparam logic [31:0]            TAPS  = 32'h8020_0003;
  localparam logic [COUNT_WIDTH-1:0] MAX_W = COUNT_WIDTH'(ERR_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PLACE = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    logic [31:0] shifted;
    shifted = {1'b0, v[31:1]};
    return v[0] ? (shifted ^ TAPS) : shifted;
  endfunction

  state_t                 state;
  logic [31:0]            lfsr;
  logic [COUNT_WIDTH-1:0] tgt;
  logic [IW-1:0]          idx;
  logic                   in_range;
  logic                   hit;
  logic [COUNT_WIDTH-1:0] placed_next;

  assign idx         = lfsr[IW-1:0];
  assign in_range    = (32'(idx) < 32'(ERR_WIDTH));
  assign hit         = in_range && !err_vec[idx];
  assign placed_next = err_weight + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  // Control FSM; err_weight doubles as the running placed-bit count.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      tgt           <= '0;
      busy          <= 1'b0;
      sat           <= 1'b0;
      err_vec_valid <= 1'b0;
      err_vec       <= '0;
      err_weight    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_load) begin
            lfsr <= (seed == 32'd0) ? LFSR_SEED : seed;
          end
          if (start) begin
            tgt   <= (target_weight > MAX_W) ? MAX_W : target_weight;
            sat   <= (target_weight > MAX_W);
            busy  <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          err_vec    <= '0;
          err_weight <= '0;
          if (tgt == '0) begin
            err_vec_valid <= 1'b1;
            state         <= OUT;
          end else begin
            state <= PLACE;
          end
        end
        PLACE: begin
          lfsr <= lfsr_step(lfsr);
          // Collisions and out-of-range indices burn the cycle without placing.
          if (hit) begin
            err_vec[idx] <= 1'b1;
            err_weight   <= placed_next;
            if (placed_next == tgt) begin
              err_vec_valid <= 1'b1;
              state         <= OUT;
            end
          end
        end
        OUT: begin
          if (err_vec_ready) begin
            err_vec_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_errbit_pattern_gen.sv
// Randomised self-checking bench for errbit_pattern_gen with a
// transaction-level reference model and a per-cycle compare process.
module tb_errbit_pattern_gen;

  localparam int          EW   = 128;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          seed_load = 1'b0;
  logic [31:0]   seed = 32'd0;
  logic          start = 1'b0;
  logic [7:0]    target_weight = 8'd0;
  logic          busy, sat, err_vec_valid;
  logic          err_vec_ready = 1'b1;
  logic [EW-1:0] err_vec;
  logic [7:0]    err_weight;

  errbit_pattern_gen dut (
    .sys_clk(sys_clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .start(start), .target_weight(target_weight), .busy(busy), .sat(sat),
    .err_vec_valid(err_vec_valid), .err_vec_ready(err_vec_ready),
    .err_vec(err_vec), .err_weight(err_weight)
  );

  always #5 sys_clk = ~sys_clk;

  int nchecks = 0;
  int nerr = 0;
  bit check_en = 1'b0;

  // Reference model state: whole patterns are computed at request time.
  logic [31:0]   m_lfsr = SEED;
  bit            m_busy = 1'b0, m_valid = 1'b0, m_sat = 1'b0;
  bit            p_sat;
  logic [EW-1:0] m_vec, p_vec;
  int            m_w, p_w, p_n;
  int            m_rem = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] next_lfsr(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // Draw candidates until the clamped weight is reached.
  task automatic gen_model(input int tw);
    int tgt, cnt, idx;
    tgt = (tw > EW) ? EW : tw;
    p_sat = (tw > EW);
    p_vec = '0;
    cnt = 0;
    p_n = 0;
    while (cnt < tgt && p_n < 200000) begin
      idx = int'(m_lfsr[6:0]);
      m_lfsr = next_lfsr(m_lfsr);
      p_n++;
      if (!p_vec[idx]) begin
        p_vec[idx] = 1'b1;
        cnt++;
      end
    end
    p_w = cnt;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_busy = 1'b0; m_valid = 1'b0; m_rem = 0; m_lfsr = SEED;
    end else if (!m_busy) begin
      if (seed_load) m_lfsr = (seed == 32'd0) ? SEED : seed;
      if (start) begin
        gen_model(int'(target_weight));
        m_busy = 1'b1;
        m_rem = 1 + p_n;
      end
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_valid = 1'b1; m_vec = p_vec; m_w = p_w; m_sat = p_sat;
      end
    end else if (m_valid && err_vec_ready) begin
      m_valid = 1'b0; m_busy = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    #1;
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge sys_clk) begin
    if (check_en) begin
      check("busy", EW'(busy), EW'(m_busy));
      check("valid", EW'(err_vec_valid), EW'(m_valid));
      if (m_valid) begin
        check("err_vec", err_vec, m_vec);
        check("err_weight", EW'(err_weight), EW'(m_w));
        check("sat", EW'(sat), EW'(m_sat));
        check("popcount", EW'($countones(err_vec)), EW'(err_weight));
      end
    end
  end

  task automatic run_req(input int tw, output int lat);
    start = 1'b1;
    target_weight = 8'(tw);
    tick();
    start = 1'b0;
    seed_load = 1'b0;
    lat = 0;
    while (!err_vec_valid && lat < 3000) begin
      tick();
      lat++;
    end
    if (!err_vec_valid) begin
      nchecks++;
      nerr++;
      $display("FAIL timeout: no valid after %0d cycles, weight %0d", lat, tw);
    end
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_load = 1'b1;
    seed = s;
    tick();
    seed_load = 1'b0;
  endtask

  logic [EW-1:0] ref3, ref_db, v0;
  int lat;

  initial begin
    rst = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", EW'(busy), '0);
    check("rst_valid", EW'(err_vec_valid), '0);
    check("rst_vec", err_vec, '0);
    check("rst_weight", EW'(err_weight), '0);
    check("rst_sat", EW'(sat), '0);

    run_req(0, lat);
    check("w0_latency", EW'(lat), EW'(1));
    check("w0_vec", err_vec, '0);
    check("w0_weight", EW'(err_weight), '0);
    check("w0_sat", EW'(sat), '0);
    tick();
    check("w0_busy_after", EW'(busy), '0);

    run_req(3, lat);
    ref3 = err_vec;
    tick();

    load_seed(32'h1);
    run_req(1, lat);
    check("w1_latency", EW'(lat), EW'(2));
    check("w1_vec", err_vec, EW'(2));
    tick();
    run_req(5, lat);
    check("w5_weight", EW'(err_weight), EW'(5));
    tick();
    run_req(64, lat);
    check("w64_weight", EW'(err_weight), EW'(64));
    tick();

    err_vec_ready = 1'b0;
    run_req(200, lat);
    check("sat_flag", EW'(sat), EW'(1));
    check("sat_vec", err_vec, {EW{1'b1}});
    check("sat_weight", EW'(err_weight), EW'(128));
    v0 = err_vec;
    for (int i = 0; i < 10; i++) begin
      start = 1'($urandom_range(0, 1));
      target_weight = 8'($urandom_range(0, 255));
      tick();
      check("hold_vec", err_vec, v0);
      check("hold_valid", EW'(err_vec_valid), EW'(1));
    end
    start = 1'b0;
    err_vec_ready = 1'b1;
    tick();

    load_seed(32'hDEAD_BEEF);
    run_req(10, lat);
    ref_db = err_vec;
    tick();
    load_seed(32'hDEAD_BEEF);
    run_req(10, lat);
    check("determinism", err_vec, ref_db);
    tick();

    start = 1'b1;
    target_weight = 8'd64;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", EW'(busy), '0);
    check("midrst_valid", EW'(err_vec_valid), '0);
    check("midrst_vec", err_vec, '0);
    check("midrst_weight", EW'(err_weight), '0);
    check("midrst_sat", EW'(sat), '0);
    run_req(3, lat);
    check("after_rst_pattern", err_vec, ref3);
    tick();

    load_seed(32'h0);
    run_req(3, lat);
    check("seed0_pattern", err_vec, ref3);
    tick();

    seed_load = 1'b1;
    seed = 32'hDEAD_BEEF;
    run_req(10, lat);
    check("same_cycle_seed", err_vec, ref_db);
    tick();

    for (int n = 0; n < 20; n++) begin
      seed_load = 1'($urandom_range(0, 1));
      seed = (n % 5 == 0) ? 32'd0 : $urandom;
      err_vec_ready = 1'b1;
      run_req((n % 4 == 0) ? $urandom_range(100, 255) : $urandom_range(0, 40), lat);
      err_vec_ready = 1'b0;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        start = 1'($urandom_range(0, 1));
        seed_load = 1'($urandom_range(0, 1));
        seed = $urandom;
        tick();
      end
      start = 1'b0;
      seed_load = 1'b0;
      err_vec_ready = 1'b1;
      tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/errbit_pattern_gen.md
Name: errbit_pattern_gen

Overview:
- Simulation-logger companion block that generates error patterns instead of counting them.
- On request, produces an ERR_WIDTH-bit error vector with exactly a requested number of '1' bits.
- Bit positions are pseudo-random, drawn from an internal LFSR.
- The vector is XORed onto decoder input codewords for BER/FER sweeps; its weight is checkable against the team popcount counter.

Parameters:
- ERR_WIDTH, 128: width of the generated error vector.
- COUNT_WIDTH, 8: width of the weight fields; must hold ERR_WIDTH.
- LFSR_SEED, 32'hACE1_2468: LFSR value after reset; nonzero.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- seed_load  input  1  load seed into the LFSR; honoured in IDLE only.
- seed  input  32  LFSR seed; 0 is replaced by LFSR_SEED.
- start  input  1  request one pattern; accepted in IDLE only.
- target_weight  input  COUNT_WIDTH  requested number of error bits; sampled with start.
- busy  output  1  high from the accepted start until the output handshake completes.
- sat  output  1  target_weight was clamped to ERR_WIDTH for this pattern.
- err_vec_valid  output  1  err_vec / err_weight are valid.
- err_vec_ready  input  1  consumer accepts the pattern.
- err_vec  output  ERR_WIDTH  generated error pattern.
- err_weight  output  COUNT_WIDTH  number of ones in err_vec.

Behaviour:
- One clock. Reset is synchronous and active-high on rst.
- Reset (any cycle, including mid-generation or while valid):
  - state=IDLE; busy=0, err_vec_valid=0, sat=0.
  - err_vec=0, err_weight=0, internal placed count=0, LFSR=LFSR_SEED.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Advances exactly once per PLACE cycle and never otherwise.
- Candidate index: idx = LFSR[IW-1:0], where IW = clog2(ERR_WIDTH); sampled before the advance.
- FSM states IDLE, CLEAR, PLACE, OUT:
  - IDLE:
    - seed_load=1 → LFSR <= (seed==0 ? LFSR_SEED : seed).
    - start=1 → tgt <= min(target_weight, ERR_WIDTH), sat <= (target_weight > ERR_WIDTH), busy <= 1, go to CLEAR.
    - If start and seed_load are both high, the seed loads and start is accepted in the same cycle; generation uses the new seed.
  - CLEAR (1 cycle): err_vec <= 0, placed <= 0. Next state is OUT if tgt==0, else PLACE.
  - PLACE (one candidate per cycle):
    - If idx < ERR_WIDTH and err_vec[idx]==0: set err_vec[idx], placed++.
    - Otherwise (collision, or out-of-range index when ERR_WIDTH is not a power of two): the cycle is consumed with no change.
    - When placed reaches tgt in this cycle → OUT.
  - OUT:
    - err_vec_valid=1; err_weight=placed; err_vec and err_weight are held stable.
    - On err_vec_valid & err_vec_ready: valid <= 0, busy <= 0, go to IDLE.
    - err_vec and err_weight keep their values in IDLE until the next CLEAR.
- start, seed_load and target_weight are ignored outside IDLE; no queuing.
- Latency, with start accepted at cycle t:
  - tgt==0: valid at t+2.
  - Otherwise: valid at t+2+N, where N is the number of PLACE cycles. N ≥ tgt; N==tgt when there are no collisions.
  - First PLACE never collides (vector empty), so tgt==1 with power-of-two width gives valid at t+3.
- Invariant: err_weight == popcount(err_vec) == min(target_weight, ERR_WIDTH) whenever err_vec_valid=1.
- Determinism: same seed and same request sequence → bit-identical patterns.
- tgt==ERR_WIDTH terminates, because a maximal-length LFSR visits every low-IW-bit value; the output is then all ones.
- err_vec_ready held high in IDLE/CLEAR/PLACE has no effect.

Test Plan:
- Reset value check: rst for 2 cycles → busy=0, err_vec_valid=0, err_vec=0, err_weight=0, sat=0.
- Zero-weight request: start with target_weight=0 at t → err_vec_valid at t+2, err_vec=0, err_weight=0, sat=0; ready=1 → busy=0 at the next cycle.
- Weight range with popcount check: seed=32'h1, target_weight=1,5,64 (ready tied high) → popcount(err_vec)==err_weight==target each time. Weight 1 must give valid at t+3.
- Saturation and backpressure:
  - target_weight=200 → sat=1, err_vec all ones, err_weight=128.
  - Hold ready low for 10 cycles → valid and err_vec stay stable; start pulses during this window are ignored.
- Determinism and reset mid-operation:
  - Load seed 32'hDEAD_BEEF and generate weight 10 twice, reloading the seed between runs → identical err_vec.
  - Assert rst during PLACE → next cycle state is IDLE with all outputs at reset values; a subsequent start works normally.
- Seed edge cases: seed_load with seed=0 followed by a weight-3 request → pattern equals the one produced after reset. Same-cycle seed_load+start uses the new seed.
